mult_seq_ctrl: RTL and testbench

Sequencing controller for the lab's shift-add multiplier datapath: accumulator register A, multiplier shift register Q with serial input from A's LSB, and multiplicand register M. It accepts a start request and drives the Q and A control codes through load, test, add and shift steps for N bits. It reports busy and done, and the product is then available in A:Q. It contains no datapath storage of its own, only FSM state and a step counter.

---
 rtl/mult_pkg.sv | 56 +++++
 rtl/mult_step_cnt.sv | 38 +++
 rtl/mult_seq_ctrl.sv | 94 +++++++++
 tb/tb_mult_seq_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared control codes, FSM state and output decode
// for the shift-add multiplier sequencer.
package mult_pkg;

  localparam logic [1:0] Q_LOAD  = 2'b00;
  localparam logic [1:0] Q_RESET = 2'b01;
  localparam logic [1:0] Q_SHIFT = 2'b10;
  localparam logic [1:0] Q_HOLD  = 2'b11;

  localparam logic [1:0] A_HOLD  = 2'b00;
  localparam logic [1:0] A_CLEAR = 2'b01;
  localparam logic [1:0] A_ADD   = 2'b10;
  localparam logic [1:0] A_SHIFT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TEST,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [1:0] q;
    logic [1:0] a;
    logic       busy;
    logic       done;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{
    q: Q_HOLD, a: A_HOLD, busy: 1'b0, done: 1'b0
  };

  function automatic ctrl_t decode(state_e s);
    ctrl_t c;
    c = '{q: Q_HOLD, a: A_HOLD, busy: 1'b1, done: 1'b0};
    unique case (s)
      S_IDLE:  c.busy = 1'b0;
      S_LOAD: begin
        c.q = Q_LOAD;
        c.a = A_CLEAR;
      end
      S_TEST:  ;
      S_ADD:   c.a = A_ADD;
      S_SHIFT: begin
        c.q = Q_SHIFT;
        c.a = A_SHIFT;
      end
      S_DONE:  c.done = 1'b1;
      default: c.busy = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mult_step_cnt.sv
// Loadable down-counter tracking remaining test/shift
// iterations; last flags the final iteration.
module mult_step_cnt #(
  parameter int N = 4,
  localparam int W = $clog2(N + 1)
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         last_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = W'(N);
    end else if (dec_i) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == W'(1));

endmodule

// File: rtl/mult_seq_ctrl.sv
// Shift-add multiplier sequencer; define MULT_SEQ_CTRL_ERR_EN
// to add the sticky err output for start-while-busy.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int N = 4,
  localparam int W = $clog2(N + 1)
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic         q0,
  output logic [1:0]   q_ctrl,
  output logic [1:0]   a_ctrl,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] step
`ifdef MULT_SEQ_CTRL_ERR_EN
  ,
  output logic         err
`endif
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl_d;
  logic   last;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = S_TEST;
      S_TEST:  state_d = q0 ? S_ADD : S_SHIFT;
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: state_d = last ? S_DONE : S_TEST;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ctrl_d = decode(state_d);
  end

  // Outputs are registered from the next state so they
  // line up with state_q and never glitch mid-cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= CTRL_RST;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  mult_step_cnt #(
    .N(N)
  ) u_cnt (
    .clock  (clock),
    .reset_n(reset_n),
    .load_i (state_q == S_LOAD),
    .dec_i  (state_q == S_SHIFT),
    .count_o(step),
    .last_o (last)
  );

  assign q_ctrl = ctrl_q.q;
  assign a_ctrl = ctrl_q.a;
  assign busy   = ctrl_q.busy;
  assign done   = ctrl_q.done;

`ifdef MULT_SEQ_CTRL_ERR_EN
  logic err_q;
  logic err_d;

  always_comb begin
    err_d = err_q;
    if (start && state_q != S_IDLE && state_q != S_DONE) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench: N=4 and N=8 controllers each drive
// a behavioural A/Q/M datapath model.
module tb_mult_seq_ctrl;
  import mult_pkg::*;

  typedef struct {
    int prod;
    int cyc;
    int adds;
  } exp_t;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       start4 = 1'b0;
  logic       start8 = 1'b0;
  logic [1:0] q4c, a4c, q8c, a8c;
  logic       busy4, dn4, busy8, dn8;
  logic [2:0] step4;
  logic [3:0] step8;
`ifdef MULT_SEQ_CTRL_ERR_EN
  logic       err4, err8;
`endif

  logic [3:0] A4 = '0, Q4 = '0, m4 = '0, b4 = '0;
  logic [7:0] A8 = '0, Q8 = '0, m8 = '0, b8 = '0;
  logic       C4 = 1'b0, C8 = 1'b0;

  int   cnt = 0;
  int   nv = 0;
  int   nerr = 0;
  int   adds4 = 0, adds8 = 0;
  logic pl4 = 1'b0, pl8 = 1'b0;
  exp_t sb4[$];
  exp_t sb8[$];

  always #5 clock = ~clock;
  always @(posedge clock) cnt <= cnt + 1;

  mult_seq_ctrl #(.N(4)) u4 (
    .clock  (clock),
    .reset_n(rst_n),
    .start  (start4),
    .q0     (Q4[0]),
    .q_ctrl (q4c),
    .a_ctrl (a4c),
    .busy   (busy4),
    .done   (dn4),
    .step   (step4)
`ifdef MULT_SEQ_CTRL_ERR_EN
    ,
    .err    (err4)
`endif
  );

  mult_seq_ctrl #(.N(8)) u8 (
    .clock  (clock),
    .reset_n(rst_n),
    .start  (start8),
    .q0     (Q8[0]),
    .q_ctrl (q8c),
    .a_ctrl (a8c),
    .busy   (busy8),
    .done   (dn8),
    .step   (step8)
`ifdef MULT_SEQ_CTRL_ERR_EN
    ,
    .err    (err8)
`endif
  );

  task automatic chk(input string n, input int act,
                     input int req);
    nv++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", n, act, req);
    end
  endtask

  // Datapath models: Q loads the multiplier, A:Q shifts
  // right with the add carry entering A's MSB.
  always @(posedge clock) begin
    case (q4c)
      Q_LOAD:  Q4 <= b4;
      Q_RESET: Q4 <= '0;
      Q_SHIFT: Q4 <= {A4[0], Q4[3:1]};
      default: ;
    endcase
    case (a4c)
      A_CLEAR: begin A4 <= '0; C4 <= 1'b0; end
      A_ADD:   {C4, A4} <= {1'b0, A4} + {1'b0, m4};
      A_SHIFT: begin A4 <= {C4, A4[3:1]}; C4 <= 1'b0; end
      default: ;
    endcase
  end

  always @(posedge clock) begin
    case (q8c)
      Q_LOAD:  Q8 <= b8;
      Q_RESET: Q8 <= '0;
      Q_SHIFT: Q8 <= {A8[0], Q8[7:1]};
      default: ;
    endcase
    case (a8c)
      A_CLEAR: begin A8 <= '0; C8 <= 1'b0; end
      A_ADD:   {C8, A8} <= {1'b0, A8} + {1'b0, m8};
      A_SHIFT: begin A8 <= {C8, A8[7:1]}; C8 <= 1'b0; end
      default: ;
    endcase
  end

  always @(negedge clock) begin
    exp_t e;
    if (rst_n) begin
      if (pl4) chk("step4_after_load", step4, 4);
      pl4 = (q4c == Q_LOAD);
      if (pl4) adds4 = 0;
      if (a4c == A_ADD) adds4++;
      if (dn4) begin
        if (sb4.size() == 0) begin
          chk("done4_unexpected", 1, 0);
        end else begin
          e = sb4.pop_front();
          chk("done4_cycle", cnt, e.cyc);
          chk("prod4", int'({A4, Q4}), e.prod);
          chk("adds4", adds4, e.adds);
          chk("step4_done", step4, 0);
        end
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (rst_n) begin
      if (pl8) chk("step8_after_load", step8, 8);
      pl8 = (q8c == Q_LOAD);
      if (pl8) adds8 = 0;
      if (a8c == A_ADD) adds8++;
      if (dn8) begin
        if (sb8.size() == 0) begin
          chk("done8_unexpected", 1, 0);
        end else begin
          e = sb8.pop_front();
          chk("done8_cycle", cnt, e.cyc);
          chk("prod8", int'({A8, Q8}), e.prod);
          chk("adds8", adds8, e.adds);
          chk("step8_done", step8, 0);
        end
      end
    end
  end

  function automatic exp_t mk(input int m, input int b,
                              input int n, input int k);
    exp_t e;
    e.prod = m * b;
    e.adds = $countones(b);
    e.cyc  = k + 2 + 2 * n + e.adds;
    return e;
  endfunction

  task automatic idle4();
    int t = 0;
    while (busy4 && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (t >= 100) chk("idle4_timeout", 1, 0);
  endtask

  task automatic issue4(input int m, input int b);
    idle4();
    m4 = 4'(m);
    b4 = 4'(b);
    start4 = 1'b1;
    sb4.push_back(mk(m, b, 4, cnt));
    @(negedge clock);
    start4 = 1'b0;
  endtask

  task automatic issue8(input int m, input int b);
    int t = 0;
    while (busy8 && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (t >= 100) chk("idle8_timeout", 1, 0);
    m8 = 8'(m);
    b8 = 8'(b);
    start8 = 1'b1;
    sb8.push_back(mk(m, b, 8, cnt));
    @(negedge clock);
    start8 = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb4.size() != 0 || sb8.size() != 0 ||
            busy4 || busy8) && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (t >= 200) chk("drain_timeout", 1, 0);
  endtask

  task automatic chk_rst(input string n);
    chk({n, "_q4"}, q4c, 3);
    chk({n, "_a4"}, a4c, 0);
    chk({n, "_busy4"}, busy4, 0);
    chk({n, "_done4"}, dn4, 0);
    chk({n, "_step4"}, step4, 0);
    chk({n, "_busy8"}, busy8, 0);
    chk({n, "_step8"}, step8, 0);
  endtask

  initial begin
    exp_t e1;
    int   t;
    int   sh;
    repeat (3) @(negedge clock);
    chk_rst("in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk_rst("idle_hold");
    end
`ifdef MULT_SEQ_CTRL_ERR_EN
    chk("err4_reset", err4, 0);
`endif

    issue4(13, 5);
    drain();
    issue4(15, 0);
    drain();
    issue4(15, 15);
    drain();
    issue4(0, 15);
    drain();

    // start held high across a whole multiply
    idle4();
    m4 = 4'd9;
    b4 = 4'd11;
    start4 = 1'b1;
    e1 = mk(9, 11, 4, cnt);
    sb4.push_back(e1);
    sb4.push_back(mk(9, 11, 4, e1.cyc + 1));
    t = 0;
    while (cnt < e1.cyc + 2 && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (t >= 100) chk("held_timeout", 1, 0);
    chk("held_relaunch_load", q4c, 0);
    start4 = 1'b0;
    drain();
`ifdef MULT_SEQ_CTRL_ERR_EN
    chk("err4_sticky", err4, 1);
`endif

    // async reset during the second SHIFT
    issue4(13, 5);
    sh = 0;
    t = 0;
    while (sh < 2 && t < 50) begin
      @(negedge clock);
      t++;
      if (q4c == Q_SHIFT) sh++;
    end
    if (t >= 50) chk("shift_timeout", 1, 0);
    #2 rst_n = 1'b0;
    #1 chk_rst("async_rst");
`ifdef MULT_SEQ_CTRL_ERR_EN
    chk("err4_cleared", err4, 0);
`endif
    sb4.delete();
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    issue4(7, 6);
    drain();

    for (int i = 0; i < 24; i++) begin
      issue4(int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clock);
        start4 = 1'b1;
        @(negedge clock);
        start4 = 1'b0;
      end
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    drain();

    issue8(255, 129);
    drain();
    issue8(255, 255);
    drain();
    for (int i = 0; i < 10; i++) begin
      issue8(int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             nv, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1, want 0");
    $fatal(1, "timeout");
  end

endmodule
